// File: rtl/mips_run_controller.sv
// Run controller for the MIPS core: core reset sequencing, clock-enable gating, cycle counting and halt/timeout detection.
// Optional PC signature trace is built only when MIPS_RUN_TRACE_EN is defined; otherwise pc_sig is tied to zero.
module mips_run_controller #(
  parameter int          PC_W         = 32,
  parameter int          CNT_W        = 32,
  parameter int          RESET_CYCLES = 5,
  parameter int          MAX_CYCLES   = 1000,
  parameter logic [31:0] HALT_ADDR    = 32'h000000FC,
  parameter int          STALL_LIMIT  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PC_W-1:0]  pc,
  output logic             cpu_rst,
  output logic             cpu_clk_en,
  output logic             running,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_count,
  output logic [31:0]      pc_sig
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_HOLD    = 3'd1;
  localparam logic [2:0] ST_RUN     = 3'd2;
  localparam logic [2:0] ST_DONE    = 3'd3;
  localparam logic [2:0] ST_TIMEOUT = 3'd4;

  localparam int HOLD_W  = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam int STALL_W = (STALL_LIMIT > 1) ? $clog2(STALL_LIMIT) : 1;
  localparam int CMP_W   = (PC_W > 32) ? PC_W : 32;
  localparam int TW      = (CNT_W > 32) ? CNT_W : 32;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);

  logic [2:0]         state_q, state_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic               first_q, first_d;
  logic [PC_W-1:0]    prev_pc_q, prev_pc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [CMP_W-1:0]   pc_ext;
  logic [CNT_W-1:0]   cnt_inc;
  logic               enter_hold;
  logic               pc_same;
  logic               addr_hit;
  logic               stall_hit;
  logic               halt;
  logic               tmo;

  assign pc_ext     = CMP_W'(pc);
  assign enter_hold = start && ((state_q == ST_IDLE) || (state_q == ST_DONE) ||
                                (state_q == ST_TIMEOUT));

  // Exit conditions, only meaningful while in RUN; the first RUN cycle has no previous PC
  assign cnt_inc   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
  assign pc_same   = !first_q && (pc == prev_pc_q);
  assign addr_hit  = (pc_ext == CMP_W'(HALT_ADDR));
  assign stall_hit = (STALL_LIMIT > 0) && pc_same &&
                     ((32'(stall_q) + 32'd1) == 32'(STALL_LIMIT));
  assign halt      = addr_hit || stall_hit;
  assign tmo       = (TW'(cnt_inc) == TW'(MAX_CYCLES));

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    stall_d   = stall_q;
    first_d   = first_q;
    prev_pc_d = prev_pc_q;
    cnt_d     = cnt_q;
    if (enter_hold) begin
      state_d = ST_HOLD;
      hold_d  = '0;
      stall_d = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (hold_q == HOLD_LAST) begin
            state_d = ST_RUN;
            hold_d  = '0;
            first_d = 1'b1;
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end
        ST_RUN: begin
          cnt_d     = cnt_inc;
          first_d   = 1'b0;
          prev_pc_d = pc;
          stall_d   = (pc_same && (STALL_LIMIT > 0)) ? stall_q + STALL_W'(1) : '0;
          if (halt) begin
            state_d = ST_DONE;
          end else if (tmo) begin
            state_d = ST_TIMEOUT;
          end
        end
        ST_IDLE, ST_DONE, ST_TIMEOUT: state_d = state_q;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
      stall_q <= '0;
      first_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      stall_q <= stall_d;
      first_q <= first_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    prev_pc_q <= prev_pc_d;
  end

`ifdef MIPS_RUN_TRACE_EN
  logic [31:0] sig_q, sig_d;

  always_comb begin
    sig_d = sig_q;
    if (enter_hold) begin
      sig_d = '0;
    end else if (state_q == ST_RUN) begin
      sig_d = {sig_q[30:0], sig_q[31]} ^ pc_ext[31:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign pc_sig = sig_q;
`else
  assign pc_sig = 32'h0;
`endif

  // All outputs decode directly from flops, so they change only at clock edges
  assign cpu_rst     = (state_q == ST_IDLE) || (state_q == ST_HOLD);
  assign cpu_clk_en  = (state_q == ST_RUN);
  assign running     = (state_q == ST_HOLD) || (state_q == ST_RUN);
  assign done        = (state_q == ST_DONE);
  assign timeout     = (state_q == ST_TIMEOUT);
  assign cycle_count = cnt_q;

endmodule

// File: tb/tb_mips_run_controller.sv
// Directed bench for mips_run_controller: reset sequencing, address/stall halt, timeout, mid-run reset, saturation.
module tb_mips_run_controller;

  logic        clk = 1'b0;
  logic        rst, start, start2;
  logic [31:0] pc, pc2;
  logic        cpu_rst, cpu_clk_en, running, done, timeout;
  logic [31:0] cycle_count, pc_sig;
  logic        cpu_rst2, cpu_clk_en2, running2, done2, timeout2;
  logic [3:0]  cycle_count2;
  logic [31:0] pc_sig2;
  logic [31:0] exp_sig;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mips_run_controller #(.MAX_CYCLES(20)) u_dut (
    .clk(clk), .rst(rst), .start(start), .pc(pc),
    .cpu_rst(cpu_rst), .cpu_clk_en(cpu_clk_en), .running(running),
    .done(done), .timeout(timeout), .cycle_count(cycle_count), .pc_sig(pc_sig)
  );

  // Small counter, single reset cycle, stall detection off
  mips_run_controller #(.CNT_W(4), .RESET_CYCLES(1), .MAX_CYCLES(100), .STALL_LIMIT(0)) u_sat (
    .clk(clk), .rst(rst), .start(start2), .pc(pc2),
    .cpu_rst(cpu_rst2), .cpu_clk_en(cpu_clk_en2), .running(running2),
    .done(done2), .timeout(timeout2), .cycle_count(cycle_count2), .pc_sig(pc_sig2)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_run;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("entry_running", running, 1);
    chk("entry_cpu_rst", cpu_rst, 1);
    chk("entry_count", cycle_count, 0);
    chk("entry_done", done, 0);
    chk("entry_timeout", timeout, 0);
    repeat (5) tick();
    chk("run_clk_en", cpu_clk_en, 1);
    exp_sig = 32'h0;
  endtask

  task automatic run_pc(input logic [31:0] v);
    pc = v;
`ifdef MIPS_RUN_TRACE_EN
    exp_sig = {exp_sig[30:0], exp_sig[31]} ^ v;
`else
    exp_sig = 32'h0;
`endif
    tick();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start2 = 1'b0; pc = '0; pc2 = 32'h40; exp_sig = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_cpu_rst", cpu_rst, 1);
    chk("rst_clk_en", cpu_clk_en, 0);
    chk("rst_running", running, 0);
    chk("rst_done", done, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_count", cycle_count, 0);
    chk("rst_sig", pc_sig, 0);
    tick();
    chk("idle_hold", running, 0);

    // Reset hold lasts exactly five cycles
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("hold%0d_cpu_rst", i), cpu_rst, 1);
      chk($sformatf("hold%0d_running", i), running, 1);
      chk($sformatf("hold%0d_clk_en", i), cpu_clk_en, 0);
      tick();
    end
    chk("run_cpu_rst", cpu_rst, 0);
    chk("run_clk_en1", cpu_clk_en, 1);
    chk("run_running", running, 1);

    // Halt address in the 10th RUN cycle
    exp_sig = 32'h0;
    for (int k = 1; k <= 9; k++) run_pc(32'((k - 1) * 4));
    chk("addr_pre_count", cycle_count, 9);
    chk("addr_pre_done", done, 0);
    chk("trace_sig", pc_sig, exp_sig);
    run_pc(32'hFC);
    chk("addr_done", done, 1);
    chk("addr_count", cycle_count, 10);
    chk("addr_clk_en", cpu_clk_en, 0);
    chk("addr_cpu_rst", cpu_rst, 0);
    chk("addr_running", running, 0);
    chk("addr_timeout", timeout, 0);
    tick();
    chk("addr_frozen", cycle_count, 10);
    chk("addr_sticky", done, 1);

    // PC stall from RUN cycle 3; start pulse mid-run must be ignored
    start_run();
    run_pc(32'h0);
    run_pc(32'h4);
    for (int k = 3; k <= 10; k++) begin
      start = (k == 5);
      run_pc(32'h40);
    end
    start = 1'b0;
    chk("stall_pre_done", done, 0);
    chk("stall_pre_count", cycle_count, 10);
    run_pc(32'h40);
    chk("stall_done", done, 1);
    chk("stall_count", cycle_count, 11);
    chk("stall_timeout", timeout, 0);

    // Cycle budget of 20 with a PC that never halts
    start_run();
    for (int k = 1; k <= 19; k++) run_pc(32'(k * 4));
    chk("tmo_pre", timeout, 0);
    run_pc(32'd80);
    chk("tmo_flag", timeout, 1);
    chk("tmo_done", done, 0);
    chk("tmo_count", cycle_count, 20);
    chk("tmo_clk_en", cpu_clk_en, 0);
    tick();
    chk("tmo_frozen", cycle_count, 20);

    // Halt in the budget's last cycle beats timeout
    start_run();
    chk("tmo_cleared", timeout, 0);
    for (int k = 1; k <= 19; k++) run_pc(32'(k * 4));
    run_pc(32'hFC);
    chk("tie_done", done, 1);
    chk("tie_timeout", timeout, 0);
    chk("tie_count", cycle_count, 20);

    // Reset in RUN cycle 7, with start asserted alongside
    start_run();
    for (int k = 1; k <= 6; k++) run_pc(32'(k * 4));
    rst = 1'b1; start = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    chk("mid_cpu_rst", cpu_rst, 1);
    chk("mid_clk_en", cpu_clk_en, 0);
    chk("mid_running", running, 0);
    chk("mid_done", done, 0);
    chk("mid_timeout", timeout, 0);
    chk("mid_count", cycle_count, 0);
    chk("mid_sig", pc_sig, 0);
    tick();
    chk("mid_idle", running, 0);
    start_run();
    run_pc(32'h100);
    chk("rerun_count", cycle_count, 1);
    run_pc(32'hFC);
    chk("rerun_done", done, 1);
    chk("rerun_count2", cycle_count, 2);

    // Saturating 4-bit counter, constant PC with stall detection disabled
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    chk("sat_hold", cpu_rst2, 1);
    chk("sat_running", running2, 1);
    tick();
    chk("sat_clk_en", cpu_clk_en2, 1);
    repeat (20) tick();
    chk("sat_count", cycle_count2, 15);
    chk("sat_done", done2, 0);
    chk("sat_timeout", timeout2, 0);
    chk("sat_still_run", running2, 1);
    chk("sat_sig", pc_sig2, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
